// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame writer: FSM states and default constants.
package uart_pkg;

    // Frame parser states: waiting for header, length byte, payload bytes, checksum byte.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_PAY  = 2'd2,
        ST_CHK  = 2'd3
    } frameState_e;

    // Start-of-frame marker.
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    // 1 ms of inter-byte silence at 50 MHz.
    localparam int TIMEOUT_CYC_DEF = 50000;

    // Filler for the low byte of the final word of an odd-length payload.
    localparam logic [7:0] PAD_BYTE = 8'h00;

    // Payload is packed MSB-first: the earlier byte lands in the high half.
    function automatic logic [15:0] packWord(input logic [7:0] hiByte, input logic [7:0] loByte);
        return {hiByte, loByte};
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte silence watchdog for the frame writer.
// Produces a one-cycle pulse one cycle before the frame writer must flag the
// error, so the registered error pulse lands exactly TIMEOUT_CYC cycles after
// the last received byte. A clear in the same cycle always suppresses the pulse.
module uart_rx_timeout import uart_pkg::*; #(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 2);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired_o = enable_i && !clear_i && (count_q == LAST_CNT);

    // Count idle cycles while a frame is open; restart on every byte, when idle, or after firing.
    always_comb begin
        count_d = count_q + 1'b1;
        if (clear_i || !enable_i || expired_o) begin
            count_d = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_frame_writer.sv
// Framed UART byte stream to 16-bit RAM word writer.
// Frame: HDR, LEN (1..255), LEN payload bytes, CHK = XOR of LEN and payload.
// Payload is packed MSB-first into words and written as it arrives; a frame
// that fails (zero length, bad checksum, inter-byte timeout) rewinds the write
// pointer to where the frame started so its words get overwritten later.
module uart_frame_writer import uart_pkg::*; #(
    parameter int         ADDR_W      = 16,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              mclk_i,
    input  logic              rst_i,
    input  logic              rx_done_i,
    input  logic [7:0]        data_byte_i,
    input  logic              clr_addr_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [15:0]       dout_o,
    output logic              frame_done_o,
    output logic              frame_err_o,
    output logic [7:0]        frame_len_o,
    output logic              busy_o
);

    frameState_e       state_q;
    logic [ADDR_W-1:0] wrPtr_q;
    logic [ADDR_W-1:0] startPtr_q;
    logic [ADDR_W-1:0] wrPtrLive;
    logic [7:0]        chk_q;
    logic [7:0]        rem_q;
    logic [7:0]        len_q;
    logic [7:0]        hiByte_q;
    logic              half_q;
    logic              wrEn_q;
    logic [ADDR_W-1:0] ramAddr_q;
    logic [15:0]       dout_q;
    logic              frameDone_q;
    logic              frameErr_q;
    logic [7:0]        frameLen_q;
    logic              timeoutHit;

    // The pointer only advances on the edge after a write strobe, so any decision
    // taken in a write cycle (next word address, frame commit) must see the
    // post-increment value rather than the stale register.
    assign wrPtrLive = wrEn_q ? (wrPtr_q + 1'b1) : wrPtr_q;

    uart_rx_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_i    (mclk_i),
        .rst_i    (rst_i),
        .clear_i  (rx_done_i),
        .enable_i (state_q != ST_IDLE),
        .expired_o(timeoutHit)
    );

    assign wr_en_o      = wrEn_q;
    assign ram_addr_o   = ramAddr_q;
    assign dout_o       = dout_q;
    assign frame_done_o = frameDone_q;
    assign frame_err_o  = frameErr_q;
    assign frame_len_o  = frameLen_q;
    assign busy_o       = (state_q != ST_IDLE);

    // Frame parser FSM with payload packing, checksum, pointer bookkeeping and registered strobes.
    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wrPtr_q     <= '0;
            startPtr_q  <= '0;
            chk_q       <= '0;
            rem_q       <= '0;
            len_q       <= '0;
            hiByte_q    <= '0;
            half_q      <= 1'b0;
            wrEn_q      <= 1'b0;
            ramAddr_q   <= '0;
            dout_q      <= '0;
            frameDone_q <= 1'b0;
            frameErr_q  <= 1'b0;
            frameLen_q  <= '0;
        end else begin
            wrEn_q      <= 1'b0;
            frameDone_q <= 1'b0;
            frameErr_q  <= 1'b0;
            wrPtr_q     <= wrPtrLive;

            if ((state_q != ST_IDLE) && timeoutHit) begin
                frameErr_q <= 1'b1;
                wrPtr_q    <= startPtr_q;
                state_q    <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (clr_addr_i) begin
                            wrPtr_q    <= '0;
                            startPtr_q <= '0;
                        end
                        if (rx_done_i && (data_byte_i == HDR_BYTE)) begin
                            state_q <= ST_LEN;
                            if (!clr_addr_i) begin
                                startPtr_q <= wrPtrLive;
                            end
                        end
                    end

                    ST_LEN: begin
                        if (rx_done_i) begin
                            if (data_byte_i == 8'h00) begin
                                frameErr_q <= 1'b1;
                                state_q    <= ST_IDLE;
                            end else begin
                                rem_q   <= data_byte_i;
                                chk_q   <= data_byte_i;
                                len_q   <= data_byte_i;
                                half_q  <= 1'b0;
                                state_q <= ST_PAY;
                            end
                        end
                    end

                    ST_PAY: begin
                        if (rx_done_i) begin
                            chk_q <= chk_q ^ data_byte_i;
                            rem_q <= rem_q - 1'b1;
                            if (half_q) begin
                                wrEn_q    <= 1'b1;
                                ramAddr_q <= wrPtrLive;
                                dout_q    <= packWord(hiByte_q, data_byte_i);
                                half_q    <= 1'b0;
                            end else if (rem_q == 8'd1) begin
                                wrEn_q    <= 1'b1;
                                ramAddr_q <= wrPtrLive;
                                dout_q    <= packWord(data_byte_i, PAD_BYTE);
                            end else begin
                                hiByte_q <= data_byte_i;
                                half_q   <= 1'b1;
                            end
                            if (rem_q == 8'd1) begin
                                state_q <= ST_CHK;
                            end
                        end
                    end

                    ST_CHK: begin
                        if (rx_done_i) begin
                            if (data_byte_i == chk_q) begin
                                frameDone_q <= 1'b1;
                                frameLen_q  <= len_q;
                                startPtr_q  <= wrPtrLive;
                            end else begin
                                frameErr_q <= 1'b1;
                                wrPtr_q    <= startPtr_q;
                            end
                            state_q <= ST_IDLE;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_frame_writer.md
Name: uart_frame_writer

Overview:
Sits directly downstream of the UART byte receiver and consumes its `rx_done` strobe and `data_byte`. It parses a framed byte stream and packs the payload MSB-first into 16-bit words. Each word is written to a RAM through a write-enable/address/data port. Bad or stalled frames are dropped, and the write pointer is rewound so the RAM only advances on good frames.

Parameters:
- ADDR_W, 16, width of RAM word address / write pointer.
- HDR_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 50000, mclk cycles of inter-byte silence that abort a frame in progress (1 ms at 50 MHz).

Ports:
- mclk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- rx_done  in  1  one-cycle strobe from the receiver: data_byte is valid.
- data_byte  in  8  received byte, sampled only when rx_done=1.
- clr_addr  in  1  reset the write pointer to 0; honoured only in IDLE.
- wr_en  out  1  one-cycle RAM write strobe.
- ram_addr  out  ADDR_W  write address, valid while wr_en=1.
- dout  out  16  write data, valid while wr_en=1.
- frame_done  out  1  one-cycle pulse: frame accepted.
- frame_err  out  1  one-cycle pulse: frame rejected (zero length, checksum mismatch, timeout).
- frame_len  out  8  payload length of the last accepted frame.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Interface (already decided): one clock, mclk; reset rst is synchronous and active-high.
- Frame format: HDR_BYTE, LEN (1..255), LEN payload bytes, CHK.
  - CHK = XOR of LEN and all payload bytes.
- Reset:
  - All outputs 0.
  - State IDLE.
  - Write pointer wp = 0, frame start pointer sp = 0.
  - Checksum, remaining-count, byte-half flag and timeout counter all 0.
  - Reset mid-frame discards the frame with no error pulse.
- FSM states: IDLE, LEN, PAY, CHK. Transitions occur only on rx_done, except for timeout.
  - IDLE: byte == HDR_BYTE -> LEN, sp <= wp. Any other byte is ignored silently.
  - LEN: byte == 0 -> frame_err, IDLE. Otherwise rem <= byte, chk <= byte, half <= 0 -> PAY.
  - PAY:
    - chk ^= byte; rem -= 1.
    - half=0: latch byte as hi, half <= 1.
    - half=1: emit word {hi, byte}, half <= 0.
    - If rem reaches 0 with half=0 pending (odd LEN): emit {byte, 8'h00}.
    - rem reaching 0 -> CHK.
  - CHK:
    - byte == chk -> frame_done, frame_len <= LEN, sp <= wp.
    - Mismatch -> frame_err, wp <= sp (rewind).
    - Either way -> IDLE.
- Word write timing:
  - wr_en is asserted the cycle after the completing rx_done, with ram_addr = wp and dout = word.
  - wp increments on the same edge that deasserts wr_en.
  - wp wraps from 2^ADDR_W-1 to 0 with no flag.
- Pulse latency: frame_done and frame_err assert 1 cycle after the CHK/LEN rx_done.
- Timeout:
  - The counter clears on every rx_done and counts while state != IDLE.
  - On reaching TIMEOUT_CYC: frame_err pulse, wp <= sp, state -> IDLE.
  - If rx_done and the timeout terminal count coincide, rx_done wins and the counter clears.
  - No timeout in IDLE.
- clr_addr:
  - In IDLE: wp <= 0, sp <= 0 on the next edge.
  - While busy: ignored, not queued.
  - If asserted together with an rx_done of HDR_BYTE in IDLE: clear first, so sp = 0.
- Back-to-back rx_done pulses: the receiver spacing is ≥ 160 bit-clock ticks, but the block must tolerate rx_done on consecutive cycles with no lost bytes.
- A word write and a rewind never coincide: the last payload write happens before CHK is received.

Decomposition:
- Shared package uart_pkg:
  - State enum for IDLE/LEN/PAY/CHK.
  - HDR_BYTE default.
  - TIMEOUT_CYC default for 50 MHz.
- Natural sub-module: uart_rx_timeout.
  - Inputs: clear, enable.
  - Output: terminal-count pulse.
  - Parameter: TIMEOUT_CYC.
- The FSM, packing, checksum and pointers stay in the top module.

Test Plan:
1. Reset, then A5 04 11 22 33 44 CHK=04^11^22^33^44=40 -> wr_en at addr 0 dout 1122 and addr 1 dout 3344; frame_done; frame_len=4; busy back to 0.
2. Odd length: A5 03 AB CD EF CHK=03^AB^CD^EF=8A -> writes ABCD, EF00 at addr 0,1; frame_done.
3. Bad checksum: good 2-byte frame (wp=1), then A5 02 12 34 CHK=FF -> write at addr 1 occurs, frame_err, and the next good frame writes again at addr 1.
4. Timeout: A5 04 01, then silence for TIMEOUT_CYC cycles -> frame_err exactly TIMEOUT_CYC cycles after the last rx_done; wp restored; busy=0. The next frame completes normally.
5. Noise and zero length: bytes 00 FF 5A in IDLE -> no outputs. A5 00 -> frame_err, no writes.
6. Wrap and clr_addr: force wp = 2^ADDR_W-1, send a 4-byte frame -> writes at FFFF then 0000. clr_addr during PAY is ignored. clr_addr in IDLE -> next write at 0. Assert rst mid-PAY -> all outputs 0, no pulses.
